// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad code accumulator.
//   KEY_CLR / KEY_BS / KEY_ENT : function key codes on key_code
//   state_t                    : accumulator FSM states
//   CODE_W                     : width of the decimal code value
//   is_digit()                 : true for key codes 0-9
package keylock_pkg;

    localparam int CODE_W = 32;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_BS  = 4'hB;
    localparam logic [3:0] KEY_ENT = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        RECALC = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/digit_mac10.sv
// Combinational decimal multiply-accumulate: y_o = v_i*10 + d_i.
//   v_i : running value (CODE_W bits)
//   d_i : decimal digit 0-9
//   y_o : v_i*10 + d_i, CODE_W bits
// The x10 is done as (v<<3)+(v<<1) so no multiplier is inferred.
module digit_mac10
    import keylock_pkg::*;
(
    input  logic [CODE_W-1:0] v_i,
    input  logic [3:0]        d_i,
    output logic [CODE_W-1:0] y_o
);

    assign y_o = (v_i << 3) + (v_i << 1) + {{(CODE_W-4){1'b0}}, d_i};

endmodule

// File: rtl/keypad_code_accum.sv
// Keypad code accumulator: turns single-cycle key events into a decimal
// code value for the keylock comparator.
//   hwclk        : clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   key_valid    : key event strobe (accepted when key_ready is high)
//   key_code     : 0-9 digit, A clear, B backspace, C enter, D-F reserved
//   key_ready    : block accepts a key this cycle (IDLE or ENTRY)
//   value        : accumulated decimal code
//   digit_count  : digits currently held
//   value_valid  : 1-cycle pulse, value is a completed entry
//   entry_active : high in ENTRY/RECALC
//   err          : 1-cycle pulse, key rejected
//   dbg_state    : current FSM state, for observation
//
// Handshake: a key transfers on a rising edge where key_valid && key_ready.
// key_valid while key_ready is low is dropped; the source must not expect
// it to be held or retried.
module keypad_code_accum
    import keylock_pkg::*;
#(
    parameter int MAX_DIGITS  = 9,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int HOLD_CYC    = 16
) (
    input  logic              hwclk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              key_ready,
    output logic [CODE_W-1:0] value,
    output logic [3:0]        digit_count,
    output logic              value_valid,
    output logic              entry_active,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // 9 decimal digits are the most that always fit in 32 bits.
    generate
        if (MAX_DIGITS > 9 || MAX_DIGITS < 1) begin : g_bad_max_digits
            $error("keypad_code_accum: MAX_DIGITS must be in 1..9");
        end
    endgenerate

    localparam int IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
    localparam int TMR_W   = $clog2(CNT_MAX + 1);

    state_t            state_q;
    logic [CODE_W-1:0] value_q;
    logic [CODE_W-1:0] acc_q;       // hidden rebuild accumulator for RECALC
    logic [3:0]        count_q;
    logic [IDX_W-1:0]  idx_q;       // next stack entry to fold in RECALC
    logic [TMR_W-1:0]  tmr_q;       // idle timer in ENTRY, hold timer in HOLD
    logic              value_valid_q;
    logic              err_q;
    logic [3:0]        stack_q [MAX_DIGITS];

    logic              accept;
    logic [CODE_W-1:0] mac_v;
    logic [3:0]        mac_d;
    logic [CODE_W-1:0] mac_y;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    assign key_ready    = (state_q == IDLE) || (state_q == ENTRY);
    assign accept       = key_valid && key_ready;
    assign push_idx     = count_q[IDX_W-1:0];
    assign pop_idx      = push_idx - 1'b1;

    // The single multiply-accumulate is shared: RECALC folds the stack into
    // acc_q, otherwise a new digit is folded into value_q.
    always_comb begin
        mac_v = value_q;
        mac_d = key_code;
        if (state_q == RECALC) begin
            mac_v = acc_q;
            mac_d = stack_q[idx_q];
        end
    end

    digit_mac10 u_mac (
        .v_i (mac_v),
        .d_i (mac_d),
        .y_o (mac_y)
    );

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            value_q       <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            tmr_q         <= '0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 0; i < MAX_DIGITS; i++) stack_q[i] <= '0;
        end else begin
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                IDLE, ENTRY: begin
                    if (accept) begin
                        // Any accepted key restarts the idle timer, which
                        // also makes a key win over a same-cycle timeout.
                        tmr_q <= '0;
                        if (is_digit(key_code)) begin
                            if (count_q == 4'(MAX_DIGITS)) begin
                                err_q <= 1'b1;
                            end else begin
                                value_q           <= mac_y;
                                stack_q[push_idx] <= key_code;
                                count_q           <= count_q + 4'd1;
                                state_q           <= ENTRY;
                            end
                        end else begin
                            case (key_code)
                                KEY_CLR: begin
                                    value_q <= '0;
                                    count_q <= '0;
                                    state_q <= IDLE;
                                    for (int i = 0; i < MAX_DIGITS; i++) stack_q[i] <= '0;
                                end
                                KEY_BS: begin
                                    if (count_q == 4'd1) begin
                                        value_q    <= '0;
                                        count_q    <= '0;
                                        stack_q[0] <= '0;
                                        state_q    <= IDLE;
                                    end else if (count_q >= 4'd2) begin
                                        count_q          <= count_q - 4'd1;
                                        stack_q[pop_idx] <= '0;
                                        acc_q            <= '0;
                                        idx_q            <= '0;
                                        state_q          <= RECALC;
                                    end
                                end
                                KEY_ENT: begin
                                    if (count_q == 4'd0) begin
                                        err_q <= 1'b1;
                                    end else begin
                                        value_valid_q <= 1'b1;
                                        state_q       <= HOLD;
                                    end
                                end
                                default: err_q <= 1'b1;
                            endcase
                        end
                    end else if (state_q == ENTRY) begin
                        if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                            value_q <= '0;
                            count_q <= '0;
                            tmr_q   <= '0;
                            state_q <= IDLE;
                            for (int i = 0; i < MAX_DIGITS; i++) stack_q[i] <= '0;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                end
                RECALC: begin
                    // One digit per cycle, oldest first; value_q only
                    // changes once the last remaining digit is folded in.
                    acc_q <= mac_y;
                    idx_q <= idx_q + 1'b1;
                    if (4'(idx_q) == count_q - 4'd1) begin
                        value_q <= mac_y;
                        tmr_q   <= '0;
                        state_q <= ENTRY;
                    end
                end
                HOLD: begin
                    if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
                        value_q <= '0;
                        count_q <= '0;
                        tmr_q   <= '0;
                        state_q <= IDLE;
                        for (int i = 0; i < MAX_DIGITS; i++) stack_q[i] <= '0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign value        = value_q;
    assign digit_count  = count_q;
    assign value_valid  = value_valid_q;
    assign err          = err_q;
    assign entry_active = (state_q == ENTRY) || (state_q == RECALC);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_keypad_code_accum.sv
module tb_keypad_code_accum;

  localparam int TIMEOUT = 20;
  localparam int HOLD    = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_RECALC = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic        hwclk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [31:0] value;
  logic [3:0]  digit_count;
  logic        value_valid;
  logic        entry_active;
  logic        err;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  keypad_code_accum #(
    .MAX_DIGITS  (9),
    .TIMEOUT_CYC (TIMEOUT),
    .HOLD_CYC    (HOLD)
  ) dut (
    .hwclk        (hwclk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .value        (value),
    .digit_count  (digit_count),
    .value_valid  (value_valid),
    .entry_active (entry_active),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // drivers: called at a falling edge, key is taken on the next rising edge,
  // returns at the following falling edge with the result visible
  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge hwclk);
    key_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_value", value, 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_ready", 32'(key_ready), 32'd1);
    check("rst_vv", 32'(value_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_active", 32'(entry_active), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    idle_cycles(2);
    rst_n = 1'b1;
    @(negedge hwclk);
  endtask

  initial begin
    int cycles;
    logic [31:0] exp_v;
    n_tests   = 0;
    n_fail    = 0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    rst_n     = 1'b0;
    @(negedge hwclk);
    do_reset();

    // 1: 5,5,5,1,1,6 then enter, hold window
    press(4'd5); check("t1_v1", value, 32'd5);
    check("t1_state_entry", 32'(dbg_state), 32'(S_ENTRY));
    press(4'd5); check("t1_v2", value, 32'd55);
    press(4'd5); check("t1_v3", value, 32'd555);
    press(4'd1); check("t1_v4", value, 32'd5551);
    press(4'd1); check("t1_v5", value, 32'd55511);
    press(4'd6); check("t1_v6", value, 32'd555116);
    check("t1_count", 32'(digit_count), 32'd6);
    press(4'hC);
    check("t1_vv", 32'(value_valid), 32'd1);
    check("t1_vval", value, 32'd555116);
    check("t1_ready_hold", 32'(key_ready), 32'd0);
    check("t1_state_hold", 32'(dbg_state), 32'(S_HOLD));
    // keys offered during HOLD must be dropped without err
    key_code  = 4'd3;
    key_valid = 1'b1;
    for (int i = 1; i < HOLD; i++) begin
      @(negedge hwclk);
      check("t1_hold_value", value, 32'd555116);
      check("t1_hold_vv", 32'(value_valid), 32'd0);
      check("t1_hold_err", 32'(err), 32'd0);
    end
    key_valid = 1'b0;
    @(negedge hwclk);
    check("t1_after_value", value, 32'd0);
    check("t1_after_count", 32'(digit_count), 32'd0);
    check("t1_after_ready", 32'(key_ready), 32'd1);
    check("t1_after_state", 32'(dbg_state), 32'(S_IDLE));

    // 2: backspace with recompute
    press(4'd5); press(4'd5); press(4'd5); press(4'd1);
    press(4'd1); press(4'd6); press(4'd1);
    check("t2_v7", value, 32'd5551161);
    press(4'hB);
    check("t2_recalc_state", 32'(dbg_state), 32'(S_RECALC));
    check("t2_recalc_active", 32'(entry_active), 32'd1);
    cycles = 0;
    while (!key_ready && cycles < 50) begin
      cycles++;
      check("t2_recalc_hidden", value, 32'd5551161);
      @(negedge hwclk);
    end
    check("t2_ready_low_cycles", 32'(cycles), 32'd6);
    check("t2_value", value, 32'd555116);
    check("t2_count", 32'(digit_count), 32'd6);
    press(4'hA);
    check("t2_clr_value", value, 32'd0);
    check("t2_clr_state", 32'(dbg_state), 32'(S_IDLE));
    // single-digit backspace goes straight to IDLE
    press(4'd4); press(4'hB);
    check("t2_bs1_value", value, 32'd0);
    check("t2_bs1_state", 32'(dbg_state), 32'(S_IDLE));
    press(4'hB);
    check("t2_bs0_err", 32'(err), 32'd0);

    // 3: nine 9s, overflow digit, enter
    for (int i = 0; i < 9; i++) press(4'd9);
    check("t3_v9", value, 32'd999999999);
    check("t3_count", 32'(digit_count), 32'd9);
    press(4'd1);
    check("t3_ovf_err", 32'(err), 32'd1);
    check("t3_ovf_value", value, 32'd999999999);
    check("t3_ovf_count", 32'(digit_count), 32'd9);
    press(4'hC);
    check("t3_vv", 32'(value_valid), 32'd1);
    check("t3_vval", value, 32'd999999999);
    idle_cycles(HOLD);
    check("t3_after_value", value, 32'd0);

    // 4: enter with no digits, reserved code
    press(4'hC);
    check("t4_ent_err", 32'(err), 32'd1);
    check("t4_ent_vv", 32'(value_valid), 32'd0);
    check("t4_ent_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge hwclk);
    check("t4_err_pulse", 32'(err), 32'd0);
    press(4'hE);
    check("t4_rsv_err", 32'(err), 32'd1);
    check("t4_rsv_value", value, 32'd0);
    check("t4_rsv_vv", 32'(value_valid), 32'd0);

    // 5: inactivity timeout
    press(4'd7);
    check("t5_value", value, 32'd7);
    idle_cycles(TIMEOUT - 1);
    check("t5_before_to", value, 32'd7);
    @(negedge hwclk);
    check("t5_to_value", value, 32'd0);
    check("t5_to_state", 32'(dbg_state), 32'(S_IDLE));
    check("t5_to_err", 32'(err), 32'd0);
    check("t5_to_active", 32'(entry_active), 32'd0);
    // key arriving on the expiry cycle wins and restarts the timer
    press(4'd7);
    idle_cycles(TIMEOUT - 1);
    press(4'd4);
    check("t5_race_value", value, 32'd74);
    check("t5_race_state", 32'(dbg_state), 32'(S_ENTRY));
    idle_cycles(TIMEOUT - 1);
    check("t5_race_before", value, 32'd74);
    @(negedge hwclk);
    check("t5_race_to", value, 32'd0);

    // 6: reset mid-RECALC and mid-HOLD
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'hB);
    @(negedge hwclk);
    check("t6_in_recalc", 32'(dbg_state), 32'(S_RECALC));
    do_reset();
    exp_v = 32'd8;
    press(4'd8); press(4'hC);
    check("t6_vv", 32'(value_valid), 32'd1);
    idle_cycles(3);
    check("t6_in_hold", value, exp_v);
    do_reset();
    idle_cycles(HOLD + 2);
    check("t6_no_vv", 32'(value_valid), 32'd0);
    check("t6_final_value", value, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
